fpu_addsub_sched: RTL and testbench
===================================

# fpu_addsub_sched

Two-requester scheduler that shares the single pipelined floating-point add/sub datapath between two independent clients. It sits between the clients and the FPU tile: it arbitrates round-robin, registers the operands into the datapath and tags each issued operation with its owner. It returns every result to the right client after the fixed pipeline latency and keeps per-client saturating operation counters for status readout.

## Interface
- REG_WIDTH, 32, operand/result width
- LATENCY, 3, cycles from operands presented on fpu_a/fpu_b to valid fpu_r (fixed; ≥1)
- CNT_WIDTH, 16, width of per-client op counters

- clk  input  1  clock, all state on rising edge
- arst  input  1  asynchronous reset, active-high
- req_valid_0 / req_valid_1  input  1  client request valid
- req_ready_0 / req_ready_1  output  1  request accepted this cycle when valid&ready
- req_a_0 / req_a_1  input  REG_WIDTH  operand A
- req_b_0 / req_b_1  input  REG_WIDTH  operand B
- req_op_0 / req_op_1  input  1  0 = add, 1 = subtract
- stall  input  1  when high no new request is accepted (in-flight ops still complete)
- fpu_en  output  1  datapath advance enable
- fpu_a, fpu_b  output  REG_WIDTH  registered operands to datapath
- fpu_op  output  1  registered operation select
- fpu_r  input  REG_WIDTH  datapath result
- rsp_valid_0 / rsp_valid_1  output  1  single-cycle result strobe per client
- rsp_data  output  REG_WIDTH  result, shared by both clients, = fpu_r
- busy  output  1  any operation issued and not yet returned
- cnt_0 / cnt_1  output  CNT_WIDTH  accepted-operation count per client

## Operation
- Arbitration: round-robin with pointer last_grant (reset = 1, so client 0 wins first tie).
  - Only one valid: that client granted. Both valid: client != last_grant granted.
  - req_ready_x = !stall & grant_x (combinational from req_valid, stall, last_grant); never both high.
  - last_grant updates only on an accepted request.
- Issue: on accept, fpu_a/fpu_b/fpu_op load the granted client's operands; otherwise hold previous value.
- Tag pipeline: shift register of LATENCY+1 stages, each {valid, id}. Stage 0 loads {accept, granted id} every cycle; stages shift when fpu_en is high.
- fpu_en = OR of all tag valid bits (stage 0 through LATENCY−1 in datapath); low when fully idle. Datapath never advances with no op in flight, never stalls with an op in flight.
- Response: when final tag stage valid, rsp_valid_{id} = 1 for one cycle, rsp_data = fpu_r. No backpressure on responses; clients must sink.
- busy = OR of all tag valid bits.
- Counters: cnt_x increments on each accept of client x; saturates at all-ones (no wrap).
- No reordering: results return in issue order, one per cycle max.

## Timing
- Reset (arst high, async): all tag stages invalid, last_grant = 1, fpu_a = fpu_b = 0, fpu_op = 0, cnt_0 = cnt_1 = 0. Outputs: req_ready_x = 0 while arst high, fpu_en = 0, rsp_valid_x = 0, busy = 0.
- Reset mid-operation: all in-flight ops dropped, no rsp_valid ever emitted for them, counters cleared.
- Accept in cycle t → operands on fpu_a/b from t+1 → rsp_valid in cycle t+1+LATENCY. Total latency LATENCY+1.
- Throughput: one accept per cycle, back-to-back; alternating grants when both clients hold valid.
- stall high in cycle t: no accept in t, in-flight ops continue; response timing of earlier ops unaffected.
- Simultaneous accept and response in same cycle allowed, independent.
- Requester may drop req_valid without accept; no state changes.

## Test plan
- Single op: reset, client 0 valid a=0x3F800000 (1.0), b=0x40000000 (2.0), op=0 → ready_0 same cycle, rsp_valid_0 exactly LATENCY+1 cycles later with rsp_data=0x40400000, cnt_0=1, busy low after.
- Contention: both valid continuously 6 cycles → grants 0,1,0,1,0,1; responses in same order on rsp_valid_0/1 back-to-back; cnt_0=cnt_1=3.
- Stall: both valid, stall high 3 cycles mid-stream → no ready during stall, earlier ops still return at scheduled cycles, arbitration resumes with correct pointer.
- Subtract: client 1 a=0x40A00000 (5.0), b=0x40400000 (3.0), op=1 → rsp_valid_1 with 0x40000000; rsp_valid_0 never asserts.
- Reset mid-flight: issue 3 ops, assert arst 1 cycle later → no rsp_valid afterward, busy=0, counters 0, next grant goes to client 0.
- Saturation: CNT_WIDTH=4, 20 client-0 accepts → cnt_0 stays 0xF.

Source files
------------

// File: rtl/fpu_addsub_sched.sv
// ============================================================================
//  Module      : fpu_addsub_sched
//  Description : Round-robin scheduler sharing one pipelined FP add/sub
//                datapath between two clients. Registers the granted
//                operands into the datapath, tags every issued operation
//                with its owner and routes the result back to that owner
//                after the fixed datapath latency. Keeps per-client
//                saturating accept counters.
//  Ports       : clk, arst             - clock, async active-high reset
//                req_*_0 / req_*_1     - client request channels (valid/ready)
//                stall                 - blocks new accepts
//                fpu_en/fpu_a/b/op     - datapath enable and operands
//                fpu_r                 - datapath result
//                rsp_valid_0/1,rsp_data- per-client result strobes, shared data
//                busy, cnt_0, cnt_1    - status
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_addsub_sched #(
    parameter int REG_WIDTH = 32,
    parameter int LATENCY   = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 req_valid_0,
    input  logic                 req_valid_1,
    output logic                 req_ready_0,
    output logic                 req_ready_1,
    input  logic [REG_WIDTH-1:0] req_a_0,
    input  logic [REG_WIDTH-1:0] req_a_1,
    input  logic [REG_WIDTH-1:0] req_b_0,
    input  logic [REG_WIDTH-1:0] req_b_1,
    input  logic                 req_op_0,
    input  logic                 req_op_1,
    input  logic                 stall,
    output logic                 fpu_en,
    output logic [REG_WIDTH-1:0] fpu_a,
    output logic [REG_WIDTH-1:0] fpu_b,
    output logic                 fpu_op,
    input  logic [REG_WIDTH-1:0] fpu_r,
    output logic                 rsp_valid_0,
    output logic                 rsp_valid_1,
    output logic [REG_WIDTH-1:0] rsp_data,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cnt_0,
    output logic [CNT_WIDTH-1:0] cnt_1
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                 last_grant_q, last_grant_d;
    logic [REG_WIDTH-1:0] fpu_a_q, fpu_a_d;
    logic [REG_WIDTH-1:0] fpu_b_q, fpu_b_d;
    logic                 fpu_op_q, fpu_op_d;
    logic [LATENCY:0]     tag_vld_q, tag_vld_d;
    logic [LATENCY:0]     tag_id_q, tag_id_d;
    logic [CNT_WIDTH-1:0] cnt_0_q, cnt_0_d;
    logic [CNT_WIDTH-1:0] cnt_1_q, cnt_1_d;

    logic grant_0, grant_1;
    logic accept_0, accept_1, accept;
    logic adv;

    // Arbitration: a lone requester always wins; on contention the client
    // that did not win last time is granted.
    always_comb begin
        grant_0     = req_valid_0 & (~req_valid_1 | last_grant_q);
        grant_1     = req_valid_1 & (~req_valid_0 | ~last_grant_q);
        // Ready is forced low while reset is held so nothing is handshaken
        // against a design that is about to discard it.
        req_ready_0 = ~arst & ~stall & grant_0;
        req_ready_1 = ~arst & ~stall & grant_1;
        accept_0    = req_valid_0 & req_ready_0;
        accept_1    = req_valid_1 & req_ready_1;
        accept      = accept_0 | accept_1;
    end

    // The datapath only advances while an op sits in one of its stages.
    assign adv = |tag_vld_q[LATENCY-1:0];

    always_comb begin
        last_grant_d = last_grant_q;
        fpu_a_d      = fpu_a_q;
        fpu_b_d      = fpu_b_q;
        fpu_op_d     = fpu_op_q;
        cnt_0_d      = cnt_0_q;
        cnt_1_d      = cnt_1_q;
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;

        if (accept) begin
            last_grant_d = accept_1;
            fpu_a_d      = accept_1 ? req_a_1  : req_a_0;
            fpu_b_d      = accept_1 ? req_b_1  : req_b_0;
            fpu_op_d     = accept_1 ? req_op_1 : req_op_0;
        end

        if (accept_0 && (cnt_0_q != C_CNT_MAX)) cnt_0_d = cnt_0_q + C_CNT_ONE;
        if (accept_1 && (cnt_1_q != C_CNT_MAX)) cnt_1_d = cnt_1_q + C_CNT_ONE;

        // Stage 0 mirrors the operand register and is refreshed every cycle.
        if (adv) begin
            tag_vld_d[LATENCY:1] = tag_vld_q[LATENCY-1:0];
            tag_id_d[LATENCY:1]  = tag_id_q[LATENCY-1:0];
        end else begin
            // Nothing upstream is valid, so the result stage simply retires;
            // without this an op alone in the last stage would respond twice.
            tag_vld_d[LATENCY] = 1'b0;
        end
        tag_vld_d[0] = accept;
        tag_id_d[0]  = accept_1;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            last_grant_q <= 1'b1;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            fpu_op_q     <= 1'b0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            cnt_0_q      <= '0;
            cnt_1_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            fpu_a_q      <= fpu_a_d;
            fpu_b_q      <= fpu_b_d;
            fpu_op_q     <= fpu_op_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            cnt_0_q      <= cnt_0_d;
            cnt_1_q      <= cnt_1_d;
        end
    end

    assign fpu_en      = adv;
    assign fpu_a       = fpu_a_q;
    assign fpu_b       = fpu_b_q;
    assign fpu_op      = fpu_op_q;
    assign rsp_valid_0 = tag_vld_q[LATENCY] & ~tag_id_q[LATENCY];
    assign rsp_valid_1 = tag_vld_q[LATENCY] &  tag_id_q[LATENCY];
    assign rsp_data    = fpu_r;
    assign busy        = |tag_vld_q;
    assign cnt_0       = cnt_0_q;
    assign cnt_1       = cnt_1_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_addsub_sched.sv
// ============================================================================
//  Module      : tb_fpu_addsub_sched
//  Description : Directed self-checking bench for fpu_addsub_sched with a
//                table-driven pipelined FP add/sub datapath model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_addsub_sched;

    localparam int LAT = 3;

    logic        clk;
    logic        arst;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic        req_op_0, req_op_1;
    logic        stall;
    logic        fpu_en;
    logic [31:0] fpu_a, fpu_b;
    logic        fpu_op;
    logic [31:0] fpu_r;
    logic        rsp_valid_0, rsp_valid_1;
    logic [31:0] rsp_data;
    logic        busy;
    logic [15:0] cnt_0, cnt_1;

    // saturation instance (CNT_WIDTH = 4), shares the request stimulus
    logic        s_ready_0, s_ready_1, s_fpu_en, s_fpu_op;
    logic [31:0] s_fpu_a, s_fpu_b, s_rsp_data;
    logic        s_rsp_valid_0, s_rsp_valid_1, s_busy;
    logic [3:0]  s_cnt_0, s_cnt_1;
    logic [31:0] s_fpu_r;

    int n_chk;
    int n_fail;
    int r;

    fpu_addsub_sched #(.REG_WIDTH(32), .LATENCY(LAT), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .arst(arst),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .stall(stall),
        .fpu_en(fpu_en), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
        .fpu_r(fpu_r),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_data(rsp_data), .busy(busy),
        .cnt_0(cnt_0), .cnt_1(cnt_1)
    );

    fpu_addsub_sched #(.REG_WIDTH(32), .LATENCY(LAT), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .arst(arst),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(s_ready_0), .req_ready_1(s_ready_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .stall(stall),
        .fpu_en(s_fpu_en), .fpu_a(s_fpu_a), .fpu_b(s_fpu_b), .fpu_op(s_fpu_op),
        .fpu_r(s_fpu_r),
        .rsp_valid_0(s_rsp_valid_0), .rsp_valid_1(s_rsp_valid_1),
        .rsp_data(s_rsp_data), .busy(s_busy),
        .cnt_0(s_cnt_0), .cnt_1(s_cnt_1)
    );

    assign s_fpu_r = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: hand-computed IEEE-754 single results for the vectors used
    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
        case ({op, a, b})
            {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2=3
            {1'b1, 32'h40A00000, 32'h40400000}: return 32'h40000000; // 5-3=2
            {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1=2
            {1'b0, 32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2=4
            {1'b0, 32'h40800000, 32'h40800000}: return 32'h41000000; // 4+4=8
            {1'b1, 32'h40400000, 32'h40000000}: return 32'h3F800000; // 3-2=1
            {1'b1, 32'h40C00000, 32'h40400000}: return 32'h40400000; // 6-3=3
            {1'b1, 32'h41000000, 32'h3F800000}: return 32'h40E00000; // 8-1=7
            default:                            return 32'hDEADBEEF;
        endcase
    endfunction

    logic [31:0] pipe [LAT];
    always_ff @(posedge clk) begin
        if (fpu_en) begin
            pipe[0] <= fpu_fn(fpu_a, fpu_b, fpu_op);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign fpu_r = pipe[LAT-1];

    // Operand tables: client 0 adds, client 1 subtracts
    logic [31:0] c0_a [3] = '{32'h3F800000, 32'h40000000, 32'h40800000};
    logic [31:0] c0_b [3] = '{32'h3F800000, 32'h40000000, 32'h40800000};
    logic [31:0] c0_r [3] = '{32'h40000000, 32'h40800000, 32'h41000000};
    logic [31:0] c1_a [3] = '{32'h40400000, 32'h40C00000, 32'h41000000};
    logic [31:0] c1_b [3] = '{32'h40000000, 32'h40400000, 32'h3F800000};
    logic [31:0] c1_r [3] = '{32'h3F800000, 32'h40400000, 32'h40E00000};

    // Stall scenario: expected grant per cycle (-1 = none), expected response
    int          st_g   [11] = '{0, -1, -1, -1, 1, 0, -1, -1, -1, -1, -1};
    int          st_rsp [11] = '{-1, -1, -1, -1, 0, -1, -1, -1, 1, 0, -1};
    logic [31:0] st_dat [11] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h40000000, 32'h0,
                                 32'h0, 32'h0, 32'h3F800000, 32'h40800000, 32'h0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        req_a_0 = 32'h0; req_b_0 = 32'h0; req_op_0 = 1'b0;
        req_a_1 = 32'h0; req_b_1 = 32'h0; req_op_1 = 1'b0;
        stall = 1'b0;
    endtask

    task automatic do_reset;
        arst = 1'b1;
        tick;
        tick;
        arst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle_inputs();
        arst = 1'b1;
        req_valid_0 = 1'b1;
        #2;
        // ---------------- reset state ----------------
        chk1("rst_ready_0", req_ready_0, 1'b0);
        chk1("rst_fpu_en", fpu_en, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rsp_valid_0", rsp_valid_0, 1'b0);
        chk1("rst_rsp_valid_1", rsp_valid_1, 1'b0);
        chk("rst_fpu_a", fpu_a, 32'h0);
        chk("rst_cnt_0", 32'(cnt_0), 32'h0);
        req_valid_0 = 1'b0;
        tick;
        arst = 1'b0;
        tick;

        // ---------------- single op ----------------
        req_valid_0 = 1'b1; req_a_0 = 32'h3F800000; req_b_0 = 32'h40000000; req_op_0 = 1'b0;
        #1;
        chk1("single_ready_0", req_ready_0, 1'b1);
        chk1("single_ready_1", req_ready_1, 1'b0);
        tick;
        idle_inputs();
        chk("single_fpu_a", fpu_a, 32'h3F800000);
        chk("single_fpu_b", fpu_b, 32'h40000000);
        chk1("single_fpu_op", fpu_op, 1'b0);
        chk1("single_fpu_en", fpu_en, 1'b1);
        chk1("single_busy", busy, 1'b1);
        chk("single_cnt_0", 32'(cnt_0), 32'd1);
        for (int k = 1; k <= LAT + 1; k++) begin
            chk1("single_rsp_valid_0", rsp_valid_0, k == LAT + 1);
            chk1("single_rsp_valid_1", rsp_valid_1, 1'b0);
            if (k == LAT + 1) chk("single_rsp_data", rsp_data, 32'h40400000);
            tick;
        end
        chk1("single_rsp_done", rsp_valid_0, 1'b0);
        chk1("single_busy_after", busy, 1'b0);
        chk1("single_fpu_en_after", fpu_en, 1'b0);

        // ---------------- contention ----------------
        do_reset();
        for (int c = 0; c < 11; c++) begin
            r = c - (LAT + 1);
            if (c < 6) begin
                req_valid_0 = 1'b1; req_a_0 = c0_a[c/2]; req_b_0 = c0_b[c/2]; req_op_0 = 1'b0;
                req_valid_1 = 1'b1; req_a_1 = c1_a[c/2]; req_b_1 = c1_b[c/2]; req_op_1 = 1'b1;
            end else begin
                idle_inputs();
            end
            #1;
            chk1("cont_ready_0", req_ready_0, (c < 6) && (c % 2 == 0));
            chk1("cont_ready_1", req_ready_1, (c < 6) && (c % 2 == 1));
            chk1("cont_rsp_valid_0", rsp_valid_0, (r >= 0) && (r < 6) && (r % 2 == 0));
            chk1("cont_rsp_valid_1", rsp_valid_1, (r >= 0) && (r < 6) && (r % 2 == 1));
            if ((r >= 0) && (r < 6))
                chk("cont_rsp_data", rsp_data, (r % 2 == 0) ? c0_r[r/2] : c1_r[r/2]);
            tick;
        end
        chk("cont_cnt_0", 32'(cnt_0), 32'd3);
        chk("cont_cnt_1", 32'(cnt_1), 32'd3);
        chk1("cont_busy_after", busy, 1'b0);

        // ---------------- stall (last grant was client 1) ----------------
        for (int s = 0; s < 11; s++) begin
            if (s < 6) begin
                req_valid_0 = 1'b1;
                req_a_0 = (s < 5) ? c0_a[0] : c0_a[1];
                req_b_0 = (s < 5) ? c0_b[0] : c0_b[1];
                req_op_0 = 1'b0;
                req_valid_1 = 1'b1; req_a_1 = c1_a[0]; req_b_1 = c1_b[0]; req_op_1 = 1'b1;
                stall = (s >= 1) && (s <= 3);
            end else begin
                idle_inputs();
            end
            #1;
            chk1("stall_ready_0", req_ready_0, st_g[s] == 0);
            chk1("stall_ready_1", req_ready_1, st_g[s] == 1);
            chk1("stall_rsp_valid_0", rsp_valid_0, st_rsp[s] == 0);
            chk1("stall_rsp_valid_1", rsp_valid_1, st_rsp[s] == 1);
            if (st_rsp[s] >= 0) chk("stall_rsp_data", rsp_data, st_dat[s]);
            if ((s >= 1) && (s <= 3)) chk1("stall_busy", busy, 1'b1);
            tick;
        end
        chk("stall_cnt_0", 32'(cnt_0), 32'd5);
        chk("stall_cnt_1", 32'(cnt_1), 32'd4);

        // ---------------- request dropped without accept ----------------
        stall = 1'b1; req_valid_1 = 1'b1;
        #1;
        chk1("drop_ready_1", req_ready_1, 1'b0);
        tick;
        idle_inputs();
        tick;
        chk("drop_cnt_1", 32'(cnt_1), 32'd4);
        chk1("drop_busy", busy, 1'b0);

        // ---------------- subtract on client 1 ----------------
        req_valid_1 = 1'b1; req_a_1 = 32'h40A00000; req_b_1 = 32'h40400000; req_op_1 = 1'b1;
        #1;
        chk1("sub_ready_1", req_ready_1, 1'b1);
        chk1("sub_ready_0", req_ready_0, 1'b0);
        tick;
        idle_inputs();
        chk1("sub_fpu_op", fpu_op, 1'b1);
        for (int k = 1; k <= LAT + 2; k++) begin
            chk1("sub_rsp_valid_0", rsp_valid_0, 1'b0);
            chk1("sub_rsp_valid_1", rsp_valid_1, k == LAT + 1);
            if (k == LAT + 1) chk("sub_rsp_data", rsp_data, 32'h40000000);
            tick;
        end
        chk("sub_cnt_1", 32'(cnt_1), 32'd5);

        // ---------------- reset mid-flight ----------------
        for (int i = 0; i < 3; i++) begin
            req_valid_0 = 1'b1; req_a_0 = c0_a[i]; req_b_0 = c0_b[i]; req_op_0 = 1'b0;
            tick;
        end
        idle_inputs();
        tick;
        arst = 1'b1;
        #1;
        chk1("mid_busy", busy, 1'b0);
        chk1("mid_fpu_en", fpu_en, 1'b0);
        chk("mid_cnt_0", 32'(cnt_0), 32'd0);
        chk("mid_cnt_1", 32'(cnt_1), 32'd0);
        chk1("mid_rsp_valid_0", rsp_valid_0, 1'b0);
        tick;
        arst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk1("mid_no_rsp_0", rsp_valid_0, 1'b0);
            chk1("mid_no_rsp_1", rsp_valid_1, 1'b0);
            tick;
        end
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        #1;
        chk1("mid_grant_0", req_ready_0, 1'b1);
        chk1("mid_grant_1", req_ready_1, 1'b0);

        // ---------------- saturation: 20 client-0 accepts ----------------
        req_valid_1 = 1'b0;
        tick;
        for (int i = 0; i < 19; i++) tick;
        idle_inputs();
        #1;
        chk("sat_cnt_0_w4", 32'(s_cnt_0), 32'hF);
        chk("sat_cnt_0_w16", 32'(cnt_0), 32'd20);
        for (int k = 0; k < LAT + 3; k++) tick;
        chk1("sat_busy_after", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
